// File: rtl/mac_operand_sequencer.sv
// mac_operand_sequencer: buffers host operand commands, drives them into the MAC with hold timing, returns results
module mac_operand_sequencer #(
    parameter int DEPTH     = 4,
    parameter int TRI_HOLD  = 4,
    parameter int SUMP_HOLD = 2,
    parameter int TIMEOUT   = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_mode,
    input  logic        cmd_last,
    input  logic [7:0]  cmd_a,
    input  logic [7:0]  cmd_b,
    input  logic [7:0]  cmd_c,
    input  logic [7:0]  cmd_x,
    output logic [7:0]  num_a,
    output logic [7:0]  num_b,
    output logic [7:0]  num_c,
    output logic [7:0]  num_x,
    output logic        mode,
    output logic        valid_input,
    output logic        last_input,
    input  logic        valid_output,
    input  logic [16:0] final_output,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [16:0] res_data,
    output logic        res_timeout,
    output logic        busy
);
    localparam int AW = $clog2(DEPTH);
    localparam int HW = $clog2((TRI_HOLD > SUMP_HOLD ? TRI_HOLD : SUMP_HOLD) + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, DRIVE, GAP, WAIT_RES, RESULT} state_t;
    typedef struct packed {
        logic       mode;
        logic       last;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] c;
        logic [7:0] x;
    } cmd_t;

    state_t        state, state_next;
    cmd_t          mem [DEPTH];
    cmd_t          op;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic [HW-1:0] hold_cnt;
    logic [TW-1:0] wait_cnt;
    logic          captured, push, pop, hit, timeout_hit;

    assign cmd_ready   = count != (AW+1)'(DEPTH);
    assign push        = cmd_valid && cmd_ready;
    assign valid_input = state == DRIVE;
    assign last_input  = valid_input && op.last;
    assign num_a       = op.a;
    assign num_b       = op.b;
    assign num_c       = op.c;
    assign num_x       = op.x;
    assign mode        = op.mode;
    assign res_valid   = state == RESULT;
    assign busy        = state != IDLE || count != '0;

    // State register; reset drops the drive outputs immediately
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    // Next state, pop request, result capture and timeout detection
    always_comb begin
        state_next  = state;
        pop         = 1'b0;
        timeout_hit = 1'b0;
        hit         = valid_output && op.last && !captured && (state inside {DRIVE, GAP, WAIT_RES});
        case (state)
            IDLE:     if (count != '0) begin
                          pop        = 1'b1;
                          state_next = DRIVE;
                      end
            DRIVE:    if (hold_cnt == HW'(1)) state_next = GAP;
            GAP:      state_next = !op.last ? IDLE : (captured || hit) ? RESULT : WAIT_RES;
            WAIT_RES: if (hit) state_next = RESULT;
                      else if (wait_cnt == TW'(TIMEOUT - 1)) begin
                          timeout_hit = 1'b1;
                          state_next  = RESULT;
                      end
            RESULT:   if (res_ready) state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    // Command storage; last is forced high for trinomial commands on entry
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {cmd_mode, cmd_mode | cmd_last, cmd_a, cmd_b, cmd_c, cmd_x};
    end

    // FIFO pointers, operand register, hold/wait counters and result registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            op          <= '0;
            hold_cnt    <= '0;
            wait_cnt    <= '0;
            captured    <= 1'b0;
            res_data    <= '0;
            res_timeout <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
            if (pop) begin
                op       <= mem[rd_ptr];
                hold_cnt <= mem[rd_ptr].mode ? HW'(TRI_HOLD) : HW'(SUMP_HOLD);
                captured <= 1'b0;
            end else if (state == DRIVE) hold_cnt <= hold_cnt - 1'b1;
            wait_cnt <= state == WAIT_RES ? wait_cnt + 1'b1 : '0;
            if (hit) begin
                res_data <= final_output;
                captured <= 1'b1;
            end
            if (timeout_hit) begin
                res_data    <= '0;
                res_timeout <= 1'b1;
            end
            if (state == RESULT && res_ready) res_timeout <= 1'b0;
        end
    end
endmodule

// File: tb/tb_mac_operand_sequencer.sv
// tb_mac_operand_sequencer: directed vectors against a small MAC responder model
module tb_mac_operand_sequencer;
    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid, cmd_ready, cmd_mode, cmd_last;
    logic [7:0]  cmd_a, cmd_b, cmd_c, cmd_x;
    logic [7:0]  num_a, num_b, num_c, num_x;
    logic        mode, valid_input, last_input;
    logic        valid_output = 1'b0;
    logic [16:0] final_output = '0;
    logic        res_valid, res_ready, res_timeout, busy;
    logic [16:0] res_data;

    mac_operand_sequencer dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_mode(cmd_mode), .cmd_last(cmd_last), .cmd_a(cmd_a), .cmd_b(cmd_b),
        .cmd_c(cmd_c), .cmd_x(cmd_x), .num_a(num_a), .num_b(num_b), .num_c(num_c),
        .num_x(num_x), .mode(mode), .valid_input(valid_input), .last_input(last_input),
        .valid_output(valid_output), .final_output(final_output), .res_valid(res_valid),
        .res_ready(res_ready), .res_data(res_data), .res_timeout(res_timeout), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {int len; int lst; int cyc;} drv_t;
    typedef struct {logic tmo; logic [16:0] data; int cyc;} res_t;

    drv_t drives[$];
    res_t results[$];
    int   vectors = 0, miscompares = 0, cyc = 0, drv_len = 0, drv_lst = 0;
    logic mac_en = 1'b1;

    // Records each completed drive burst and each accepted result
    always @(negedge clk) begin
        cyc++;
        if (valid_input) begin
            drv_len++;
            if (last_input) drv_lst++;
        end else if (drv_len != 0) begin
            drives.push_back('{drv_len, drv_lst, cyc});
            drv_len = 0;
            drv_lst = 0;
        end
        if (res_valid && res_ready) results.push_back('{res_timeout, res_data, cyc});
    end

    logic [16:0] m_a, m_b, m_c, m_x, m_acc = '0, m_res = '0;
    logic        m_mode = 1'b0, m_last = 1'b0, m_prev = 1'b0;
    int          m_dly = 0;

    // MAC responder: answers a last term two cycles after valid_input falls
    always @(negedge clk) begin
        valid_output = 1'b0;
        if (m_dly > 0) begin
            m_dly--;
            if (m_dly == 0) begin
                valid_output = 1'b1;
                final_output = m_res;
            end
        end
        if (valid_input) begin
            m_a = 17'(num_a); m_b = 17'(num_b); m_c = 17'(num_c); m_x = 17'(num_x);
            m_mode = mode;
            m_last = last_input;
        end
        if (m_prev && !valid_input) begin
            if (m_mode) m_res = (m_a * m_x + m_b) * m_x + m_c;
            else begin
                m_acc = m_acc + m_a * m_x;
                m_res = m_acc;
            end
            if (m_last) begin
                m_acc = '0;
                if (mac_en) m_dly = 2;
            end
        end
        m_prev = valid_input;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic push(input logic m, input logic l, input logic [7:0] a, x, b, c);
        int n = 0;
        cmd_mode = m; cmd_last = l; cmd_a = a; cmd_x = x; cmd_b = b; cmd_c = c;
        cmd_valid = 1'b1;
        while (!cmd_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("push_rdy", 32'(n < 300), 1);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_results(input int n, input string tag);
        int t = 0;
        while (results.size() < n && t < 500) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
        check(tag, results.size(), n);
    endtask

    task automatic clear_logs();
        drives.delete();
        results.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc_n;
        reset = 1'b0; cmd_valid = 1'b0; res_ready = 1'b0;
        cmd_mode = 1'b0; cmd_last = 1'b0; cmd_a = '0; cmd_b = '0; cmd_c = '0; cmd_x = '0;
        repeat (2) @(negedge clk);
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_valid_input", valid_input, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_num_a", num_a, 0);
        reset = 1'b1;
        @(negedge clk);

        // Trinomial (5*3+2)*3+1 = 52 with two-cycle push-to-drive latency
        res_ready = 1'b1;
        clear_logs();
        push(1'b1, 1'b0, 8'd5, 8'd3, 8'd2, 8'd1);
        check("tri_lat_pre", valid_input, 0);
        @(negedge clk);
        check("tri_lat", valid_input, 1);
        check("tri_num_a", num_a, 5);
        check("tri_num_x", num_x, 3);
        wait_results(1, "tri_nres");
        check("tri_len", drives[0].len, 4);
        check("tri_last", drives[0].lst, 4);
        check("tri_data", results[0].data, 52);
        check("tri_tmo", results[0].tmo, 0);
        check("tri_busy", busy, 0);

        // Back-to-back trinomials: (9*8+7)*8+6 = 638, then 52
        clear_logs();
        push(1'b1, 1'b0, 8'd9, 8'd8, 8'd7, 8'd6);
        push(1'b1, 1'b0, 8'd5, 8'd3, 8'd2, 8'd1);
        wait_results(2, "b2b_nres");
        check("b2b_ndrv", drives.size(), 2);
        check("b2b_data0", results[0].data, 638);
        check("b2b_data1", results[1].data, 52);
        check("b2b_len1", drives[1].len, 4);

        // Sum of products 5*3 + 9*8 = 87
        clear_logs();
        push(1'b0, 1'b0, 8'd5, 8'd3, 8'd0, 8'd0);
        push(1'b0, 1'b1, 8'd9, 8'd8, 8'd0, 8'd0);
        wait_results(1, "sop_nres");
        check("sop_ndrv", drives.size(), 2);
        check("sop_len0", drives[0].len, 2);
        check("sop_len1", drives[1].len, 2);
        check("sop_last0", drives[0].lst, 0);
        check("sop_last1", drives[1].lst, 2);
        check("sop_data", results[0].data, 87);

        // Backpressure: six trinomials (a=i+1,x=2,b=i,c=3) -> 7,13,19,25,31,37
        clear_logs();
        res_ready = 1'b0;
        acc_n = 0;
        for (int t = 0; t < 40; t++) begin
            cmd_mode = 1'b1; cmd_last = 1'b0; cmd_a = 8'(acc_n + 1); cmd_x = 8'd2;
            cmd_b = 8'(acc_n); cmd_c = 8'd3; cmd_valid = acc_n < 6;
            if (cmd_valid && cmd_ready) acc_n++;
            @(negedge clk);
        end
        check("full_accepted", acc_n, 5);
        check("full_ready", cmd_ready, 0);
        check("full_res_valid", res_valid, 1);
        res_ready = 1'b1;
        for (int t = 0; t < 400 && (acc_n < 6 || results.size() < 6); t++) begin
            cmd_a = 8'(acc_n + 1); cmd_b = 8'(acc_n); cmd_valid = acc_n < 6;
            if (cmd_valid && cmd_ready) acc_n++;
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        wait_results(6, "full_nres");
        for (int i = 0; i < 6; i++) check("full_data", results[i].data, 32'(6 * i + 7));

        // Timeout: no MAC response, then a normal command
        clear_logs();
        mac_en = 1'b0;
        push(1'b1, 1'b0, 8'd1, 8'd1, 8'd1, 8'd1);
        wait_results(1, "tmo_nres");
        check("tmo_flag", results[0].tmo, 1);
        check("tmo_data", results[0].data, 0);
        check("tmo_lat", results[0].cyc - drives[0].cyc, TIMEOUT + 1);
        mac_en = 1'b1;
        clear_logs();
        push(1'b1, 1'b0, 8'd5, 8'd3, 8'd2, 8'd1);
        wait_results(1, "post_tmo_nres");
        check("post_tmo_data", results[0].data, 52);
        check("post_tmo_flag", results[0].tmo, 0);

        // Reset during the second drive cycle with a second command buffered
        mac_en = 1'b0;
        push(1'b1, 1'b0, 8'd5, 8'd3, 8'd2, 8'd1);
        push(1'b1, 1'b0, 8'd9, 8'd8, 8'd7, 8'd6);
        check("rstm_drive1", valid_input, 1);
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check("rstm_valid_input", valid_input, 0);
        check("rstm_last_input", last_input, 0);
        check("rstm_cmd_ready", cmd_ready, 1);
        check("rstm_busy", busy, 0);
        @(negedge clk);
        #1;
        clear_logs();
        reset = 1'b1;
        repeat (12) @(negedge clk);
        check("rstm_no_drive", drives.size(), 0);
        check("rstm_no_res", res_valid, 0);
        check("rstm_idle", busy, 0);
        mac_en = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
